aes_key_schedule: RTL



---
 rtl/aes_key_schedule.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/aes_key_schedule.sv
// AES-128 sequential key expansion: one keygen round per clock, round keys
// held in a key store with a registered read port.

// Single AES-128 key-expansion round, purely combinational.
module aes_keygen (
   input  logic [3:0]   round_num,
   input  logic [127:0] key_in,
   output logic [127:0] key_out
);

   // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // General GF(2^8) multiply by shift-and-add.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   // S-box: multiplicative inverse (x^254, zero maps to zero) then affine map.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] inv;
      inv = 8'h01;
      for (int i = 7; i >= 0; i--) begin
         inv = gf_mul(inv, inv);
         if (i != 0) inv = gf_mul(inv, x);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   // Round constant for rounds 0..9; other indices are outside the legal range.
   function automatic logic [7:0] rcon(input logic [3:0] r);
      case (r)
         4'd0:    return 8'h01;
         4'd1:    return 8'h02;
         4'd2:    return 8'h04;
         4'd3:    return 8'h08;
         4'd4:    return 8'h10;
         4'd5:    return 8'h20;
         4'd6:    return 8'h40;
         4'd7:    return 8'h80;
         4'd8:    return 8'h1b;
         4'd9:    return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   logic [31:0] w0, w1, w2, w3;
   logic [31:0] rot, sub, n0, n1, n2, n3;

   // RotWord/SubWord/Rcon on the last word, then the xor chain across words.
   always_comb begin
      w0  = key_in[127:96];
      w1  = key_in[95:64];
      w2  = key_in[63:32];
      w3  = key_in[31:0];
      rot = {w3[23:0], w3[31:24]};
      sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
      n0  = w0 ^ sub ^ {rcon(round_num), 24'h000000};
      n1  = w1 ^ n0;
      n2  = w2 ^ n1;
      n3  = w3 ^ n2;
      key_out = {n0, n1, n2, n3};
   end

endmodule

module aes_key_schedule #(
   parameter int unsigned NR = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] key_in,
   output logic         busy,
   output logic         key_ready,
   output logic         done,
   input  logic [3:0]   rd_addr,
   output logic [127:0] rd_key
);

   localparam int unsigned KEY_W = 128;
   localparam int unsigned RC_W  = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXPAND = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t           state;
   logic [RC_W-1:0]  rc;
   logic [KEY_W-1:0] work;
   logic [KEY_W-1:0] nxt;
   logic [KEY_W-1:0] store [0:NR];

   aes_keygen u_keygen (
      .round_num (rc),
      .key_in    (work),
      .key_out   (nxt)
   );

   // Control FSM, key store writes and registered read port.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         rc        <= '0;
         work      <= '0;
         busy      <= 1'b0;
         key_ready <= 1'b0;
         done      <= 1'b0;
         rd_key    <= '0;
         for (int i = 0; i <= int'(NR); i++) store[i] <= '0;
      end else begin
         done <= 1'b0;

         // Read sees pre-edge store contents; no bypass of a same-edge write.
         if (rd_addr <= RC_W'(NR)) rd_key <= store[rd_addr];
         else                      rd_key <= '0;

         case (state)
            IDLE, DONE: begin
               if (start) begin
                  store[0]  <= key_in;
                  work      <= key_in;
                  rc        <= '0;
                  busy      <= 1'b1;
                  key_ready <= 1'b0;
                  state     <= EXPAND;
               end
            end
            EXPAND: begin
               store[rc + RC_W'(1)] <= nxt;
               work                 <= nxt;
               rc                   <= rc + RC_W'(1);
               if (rc == RC_W'(NR - 1)) begin
                  busy      <= 1'b0;
                  key_ready <= 1'b1;
                  done      <= 1'b1;
                  state     <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
